// File: rtl/instruction_fetch.sv
// instruction_fetch
// Initiator side of the instruction-memory request/response interface. It owns
// the PC and keeps at most one read request outstanding. Each returned
// instruction is presented to decode through a valid/ready handshake. The
// block also handles branch redirects, drops stale responses, and stops for
// good once decode accepts HALT_INST.
//
// Ports:
//   i_clk, i_rst_n                clock (rising edge), async active-low reset
//   o_imem_valid, o_imem_addr     one-cycle request pulse, address held until next request
//   i_imem_valid, i_imem_inst     one-cycle response pulse and data
//   o_inst_valid, o_inst, o_pc    instruction and its byte address for decode
//   i_inst_ready                  decode ready
//   i_redirect, i_redirect_pc     one-cycle redirect and its target
//   o_halt                        sticky, set once HALT_INST is accepted
//   o_state                       current FSM state (debug)
//
// Handshake: decode takes o_inst/o_pc on every rising edge where
// o_inst_valid & i_inst_ready. While o_inst_valid=1 and i_inst_ready=0, the
// outputs are held stable. Memory handshakes are single-cycle pulses in both
// directions and carry no backpressure.
`timescale 1ns/1ps
module instruction_fetch #(
    parameter int                 ADDR_W    = 64,
    parameter int                 INST_W    = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC  = '0,
    parameter logic [INST_W-1:0]  HALT_INST = 32'hFFFFFFFF
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    output logic              o_imem_valid,
    output logic [ADDR_W-1:0] o_imem_addr,
    input  logic              i_imem_valid,
    input  logic [INST_W-1:0] i_imem_inst,
    output logic              o_inst_valid,
    output logic [INST_W-1:0] o_inst,
    output logic [ADDR_W-1:0] o_pc,
    input  logic              i_inst_ready,
    input  logic              i_redirect,
    input  logic [ADDR_W-1:0] i_redirect_pc,
    output logic              o_halt,
    output logic [1:0]        o_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_HALT = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              drop_q, drop_d;
    logic              imem_valid_q, imem_valid_d;
    logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
    logic              inst_valid_q, inst_valid_d;
    logic [INST_W-1:0] inst_q, inst_d;
    logic [ADDR_W-1:0] out_pc_q, out_pc_d;
    logic              halt_q, halt_d;

    logic              accept;
    logic [ADDR_W-1:0] pc_plus4;

    assign accept   = inst_valid_q & i_inst_ready;
    assign pc_plus4 = pc_q + ADDR_W'(4);   // wraps modulo 2^ADDR_W

    // State and datapath registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            drop_q       <= 1'b0;
            imem_valid_q <= 1'b0;
            imem_addr_q  <= '0;
            inst_valid_q <= 1'b0;
            inst_q       <= '0;
            out_pc_q     <= '0;
            halt_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drop_q       <= drop_d;
            imem_valid_q <= imem_valid_d;
            imem_addr_q  <= imem_addr_d;
            inst_valid_q <= inst_valid_d;
            inst_q       <= inst_d;
            out_pc_q     <= out_pc_d;
            halt_q       <= halt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: state_d = S_WAIT;
            S_WAIT: begin
                // A redirect or a stale response keeps us waiting.
                if (!i_redirect && i_imem_valid && !drop_q) state_d = S_HOLD;
            end
            S_HOLD: begin
                if (i_redirect)                    state_d = S_WAIT;
                else if (accept && inst_q == HALT_INST) state_d = S_HALT;
                else if (accept)                   state_d = S_WAIT;
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    // Output / datapath next values. A redirect beats every other event.
    always_comb begin
        pc_d         = pc_q;
        drop_d       = drop_q;
        imem_valid_d = 1'b0;
        imem_addr_d  = imem_addr_q;
        inst_valid_d = inst_valid_q;
        inst_d       = inst_q;
        out_pc_d     = out_pc_q;
        halt_d       = halt_q;
        unique case (state_q)
            S_IDLE: begin
                imem_valid_d = 1'b1;
                if (i_redirect) begin
                    pc_d        = i_redirect_pc;
                    imem_addr_d = i_redirect_pc;
                end else begin
                    imem_addr_d = pc_q;
                end
            end
            S_WAIT: begin
                if (i_redirect) begin
                    pc_d = i_redirect_pc;
                    if (i_imem_valid) begin
                        // The outstanding response arrives now and is thrown
                        // away, so the new request can go out immediately.
                        drop_d       = 1'b0;
                        imem_valid_d = 1'b1;
                        imem_addr_d  = i_redirect_pc;
                    end else begin
                        // The response is still in flight. Mark it stale.
                        drop_d = 1'b1;
                    end
                end else if (i_imem_valid) begin
                    if (drop_q) begin
                        drop_d       = 1'b0;
                        imem_valid_d = 1'b1;
                        imem_addr_d  = pc_q;
                    end else begin
                        inst_d       = i_imem_inst;
                        out_pc_d     = pc_q;
                        inst_valid_d = 1'b1;
                    end
                end
            end
            S_HOLD: begin
                if (i_redirect) begin
                    // Squash the held instruction, even if accepted this cycle.
                    inst_valid_d = 1'b0;
                    pc_d         = i_redirect_pc;
                    imem_valid_d = 1'b1;
                    imem_addr_d  = i_redirect_pc;
                end else if (accept) begin
                    inst_valid_d = 1'b0;
                    if (inst_q == HALT_INST) begin
                        halt_d = 1'b1;
                    end else begin
                        pc_d         = pc_plus4;
                        imem_valid_d = 1'b1;
                        imem_addr_d  = pc_plus4;
                    end
                end
            end
            default: ;
        endcase
    end

    assign o_imem_valid = imem_valid_q;
    assign o_imem_addr  = imem_addr_q;
    assign o_inst_valid = inst_valid_q;
    assign o_inst       = inst_q;
    assign o_pc         = out_pc_q;
    assign o_halt       = halt_q;
    assign o_state      = state_q;

endmodule

// File: tb/tb_instruction_fetch.sv
`timescale 1ns/1ps
module tb_instruction_fetch;

  localparam logic [31:0] HALT = 32'hFFFFFFFF;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        o_imem_valid;
  logic [63:0] o_imem_addr;
  logic        i_imem_valid;
  logic [31:0] i_imem_inst;
  logic        o_inst_valid;
  logic [31:0] o_inst;
  logic [63:0] o_pc;
  logic        i_inst_ready;
  logic        i_redirect;
  logic [63:0] i_redirect_pc;
  logic        o_halt;
  logic [1:0]  o_state;

  // memory model and manual response override
  logic        mem_auto = 1'b0;
  logic        mem_rsp_v = 1'b0;
  logic [31:0] mem_inst = '0;
  logic        man_rsp_v = 1'b0;
  logic [31:0] man_inst = '0;
  logic [31:0] mem [64];
  logic        mem_pend = 1'b0;
  int          mem_cnt = 0;
  logic [63:0] mem_addr = '0;
  logic [63:0] req_log[$];

  logic [31:0] seq_exp[4];
  logic [31:0] d_inst[$];
  logic [63:0] d_pc[$];

  int n_checks = 0;
  int n_errors = 0;

  assign i_imem_valid = mem_rsp_v | man_rsp_v;
  assign i_imem_inst  = man_rsp_v ? man_inst : mem_inst;

  always #5 i_clk = ~i_clk;

  instruction_fetch dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .o_imem_valid(o_imem_valid), .o_imem_addr(o_imem_addr),
    .i_imem_valid(i_imem_valid), .i_imem_inst(i_imem_inst),
    .o_inst_valid(o_inst_valid), .o_inst(o_inst), .o_pc(o_pc),
    .i_inst_ready(i_inst_ready),
    .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc),
    .o_halt(o_halt), .o_state(o_state)
  );

  // memory: logs every request, answers after a fixed delay when enabled
  always @(negedge i_clk) begin
    mem_rsp_v = 1'b0;
    if (!i_rst_n) begin
      mem_pend = 1'b0;
    end else begin
      if (mem_pend) begin
        if (mem_cnt == 0) begin
          mem_rsp_v = 1'b1;
          mem_inst  = mem[mem_addr[7:2]];
          mem_pend  = 1'b0;
        end else begin
          mem_cnt--;
        end
      end
      if (o_imem_valid) begin
        req_log.push_back(o_imem_addr);
        if (mem_auto) begin
          mem_pend = 1'b1;
          mem_cnt  = 4;
          mem_addr = o_imem_addr;
        end
      end
    end
  end

  task automatic do_reset;
    i_rst_n = 1'b0; i_redirect = 1'b0; i_redirect_pc = '0;
    i_inst_ready = 1'b0; man_rsp_v = 1'b0; man_inst = '0; mem_auto = 1'b0;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
  endtask

  task automatic wait_inst_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge i_clk);
      if (o_inst_valid) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset;
    i_rst_n = 1'b0; i_redirect = 1'b0; i_redirect_pc = '0;
    i_inst_ready = 1'b0;
    #1;
    n_checks++;
    if (o_imem_valid !== 1'b0 || o_imem_addr !== 64'd0 || o_inst_valid !== 1'b0) begin
      $display("FAIL reset_req: imem_valid=%b addr=%0h inst_valid=%b, required 0/0/0", o_imem_valid, o_imem_addr, o_inst_valid);
      n_errors++;
    end
    n_checks++;
    if (o_inst !== 32'd0 || o_pc !== 64'd0 || o_halt !== 1'b0 || o_state !== 2'd0) begin
      $display("FAIL reset_out: inst=%0h pc=%0h halt=%b state=%0d, required 0/0/0/0", o_inst, o_pc, o_halt, o_state);
      n_errors++;
    end
  endtask

  task automatic test_sequential;
    int base;
    bit done;
    do_reset;
    mem_auto = 1'b1; i_inst_ready = 1'b1;
    base = req_log.size();
    d_inst.delete(); d_pc.delete();
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge i_clk);
      if (o_inst_valid && i_inst_ready) begin
        d_inst.push_back(o_inst); d_pc.push_back(o_pc);
      end
      if (o_halt) done = 1'b1;
    end
    n_checks++;
    if (!done) begin $display("FAIL seq_halt: o_halt never rose within 300 cycles"); n_errors++; end
    n_checks++;
    if (d_pc.size() != 4) begin
      $display("FAIL seq_count: %0d deliveries, required 4", d_pc.size()); n_errors++;
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (d_pc[i] !== 64'(4 * i) || d_inst[i] !== seq_exp[i]) begin
          $display("FAIL seq_deliv%0d: pc=%0h inst=%0h, required pc=%0h inst=%0h", i, d_pc[i], d_inst[i], 4 * i, seq_exp[i]);
          n_errors++;
        end
      end
    end
    repeat (20) @(posedge i_clk);
    #1;
    n_checks++;
    if (req_log.size() != base + 4) begin
      $display("FAIL seq_req_count: %0d requests, required 4", req_log.size() - base); n_errors++;
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (req_log[base + i] !== 64'(4 * i)) begin
          $display("FAIL seq_req%0d: addr=%0h, required %0h", i, req_log[base + i], 4 * i); n_errors++;
        end
      end
    end
    n_checks++;
    if (o_state !== 2'd3 || o_halt !== 1'b1) begin
      $display("FAIL seq_final: state=%0d halt=%b, required 3/1", o_state, o_halt); n_errors++;
    end
  endtask

  task automatic test_backpressure;
    int base;
    bit ok;
    do_reset;
    mem_auto = 1'b1; i_inst_ready = 1'b0;
    base = req_log.size();
    wait_inst_valid(ok);
    n_checks++;
    if (!ok) begin $display("FAIL bp_first_valid: no o_inst_valid within 100 cycles"); n_errors++; end
    for (int i = 0; i < 10; i++) begin
      @(negedge i_clk);
      n_checks++;
      if (o_inst_valid !== 1'b1 || o_inst !== 32'h00000013 || o_pc !== 64'd0) begin
        $display("FAIL bp_hold%0d: valid=%b inst=%0h pc=%0h, required 1/13/0", i, o_inst_valid, o_inst, o_pc);
        n_errors++;
      end
    end
    i_inst_ready = 1'b1;
    @(posedge i_clk);
    #1;
    n_checks++;
    if (req_log.size() != base + 1) begin
      $display("FAIL bp_no_req: %0d requests during stall, required 1", req_log.size() - base); n_errors++;
    end
    n_checks++;
    if (o_imem_valid !== 1'b1 || o_imem_addr !== 64'd4 || o_inst_valid !== 1'b0) begin
      $display("FAIL bp_next_req: imem_valid=%b addr=%0h inst_valid=%b, required 1/4/0", o_imem_valid, o_imem_addr, o_inst_valid);
      n_errors++;
    end
  endtask

  task automatic test_redirect_wait;
    int base;
    bit ok;
    do_reset;
    mem_auto = 1'b1; i_inst_ready = 1'b1;
    base = req_log.size();
    @(posedge i_clk); #1;
    n_checks++;
    if (o_imem_valid !== 1'b1 || o_imem_addr !== 64'd0) begin
      $display("FAIL rw_first_req: valid=%b addr=%0h, required 1/0", o_imem_valid, o_imem_addr); n_errors++;
    end
    @(posedge i_clk); #1;
    @(posedge i_clk); #1;
    i_redirect = 1'b1; i_redirect_pc = 64'd64;
    @(posedge i_clk); #1;
    i_redirect = 1'b0;
    wait_inst_valid(ok);
    n_checks++;
    if (!ok || o_pc !== 64'd64 || o_inst !== mem[16]) begin
      $display("FAIL rw_deliver: ok=%b pc=%0h inst=%0h, required 1/40/%0h", ok, o_pc, o_inst, mem[16]);
      n_errors++;
    end
    @(posedge i_clk); #1;
    n_checks++;
    if (req_log.size() != base + 2) begin
      $display("FAIL rw_req_count: %0d requests, required 2", req_log.size() - base); n_errors++;
    end else begin
      n_checks++;
      if (req_log[base] !== 64'd0 || req_log[base + 1] !== 64'd64) begin
        $display("FAIL rw_req_addr: %0h,%0h, required 0,40", req_log[base], req_log[base + 1]); n_errors++;
      end
    end
  endtask

  task automatic test_redirect_same_cycle;
    bit ok;
    // response and redirect on the same edge while waiting
    do_reset;
    i_inst_ready = 1'b1;
    repeat (3) begin @(posedge i_clk); #1; end
    man_rsp_v = 1'b1; man_inst = HALT;
    i_redirect = 1'b1; i_redirect_pc = 64'd128; mem_auto = 1'b1;
    @(posedge i_clk); #1;
    man_rsp_v = 1'b0; i_redirect = 1'b0;
    n_checks++;
    if (o_imem_valid !== 1'b1 || o_imem_addr !== 64'd128 || o_inst_valid !== 1'b0) begin
      $display("FAIL rs_wait_req: imem_valid=%b addr=%0h inst_valid=%b, required 1/80/0", o_imem_valid, o_imem_addr, o_inst_valid);
      n_errors++;
    end
    wait_inst_valid(ok);
    n_checks++;
    if (!ok || o_pc !== 64'd128 || o_inst !== mem[32] || o_halt !== 1'b0) begin
      $display("FAIL rs_wait_deliver: ok=%b pc=%0h inst=%0h halt=%b, required 1/80/%0h/0", ok, o_pc, o_inst, o_halt, mem[32]);
      n_errors++;
    end
    // redirect in HOLD with accept on the same edge, held word is HALT
    do_reset;
    i_inst_ready = 1'b0;
    repeat (2) begin @(posedge i_clk); #1; end
    man_rsp_v = 1'b1; man_inst = HALT;
    @(posedge i_clk); #1;
    man_rsp_v = 1'b0;
    n_checks++;
    if (o_inst_valid !== 1'b1 || o_inst !== HALT || o_pc !== 64'd0) begin
      $display("FAIL rs_hold_setup: valid=%b inst=%0h pc=%0h, required 1/ffffffff/0", o_inst_valid, o_inst, o_pc);
      n_errors++;
    end
    i_inst_ready = 1'b1; i_redirect = 1'b1; i_redirect_pc = 64'd128; mem_auto = 1'b1;
    @(posedge i_clk); #1;
    i_redirect = 1'b0;
    n_checks++;
    if (o_halt !== 1'b0 || o_inst_valid !== 1'b0 || o_imem_valid !== 1'b1 || o_imem_addr !== 64'd128) begin
      $display("FAIL rs_hold_req: halt=%b inst_valid=%b imem_valid=%b addr=%0h, required 0/0/1/80", o_halt, o_inst_valid, o_imem_valid, o_imem_addr);
      n_errors++;
    end
    wait_inst_valid(ok);
    n_checks++;
    if (!ok || o_pc !== 64'd128) begin
      $display("FAIL rs_hold_deliver: ok=%b pc=%0h, required 1/80", ok, o_pc); n_errors++;
    end
  endtask

  task automatic test_halt_gating;
    int base;
    do_reset;
    i_inst_ready = 1'b1;
    repeat (2) begin @(posedge i_clk); #1; end
    man_rsp_v = 1'b1; man_inst = HALT;
    @(posedge i_clk); #1;
    man_rsp_v = 1'b0;
    @(posedge i_clk); #1;
    n_checks++;
    if (o_halt !== 1'b1 || o_state !== 2'd3 || o_inst_valid !== 1'b0) begin
      $display("FAIL hg_halt: halt=%b state=%0d inst_valid=%b, required 1/3/0", o_halt, o_state, o_inst_valid);
      n_errors++;
    end
    base = req_log.size();
    i_redirect = 1'b1; i_redirect_pc = 64'd64; man_rsp_v = 1'b1; man_inst = 32'h00000013;
    @(posedge i_clk); #1;
    i_redirect = 1'b0; man_rsp_v = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge i_clk);
      n_checks++;
      if (o_halt !== 1'b1 || o_imem_valid !== 1'b0 || o_inst_valid !== 1'b0) begin
        $display("FAIL hg_static%0d: halt=%b imem_valid=%b inst_valid=%b, required 1/0/0", i, o_halt, o_imem_valid, o_inst_valid);
        n_errors++;
      end
    end
    @(posedge i_clk); #1;
    n_checks++;
    if (req_log.size() != base) begin
      $display("FAIL hg_no_req: %0d requests after halt, required 0", req_log.size() - base); n_errors++;
    end
  endtask

  task automatic test_reset_wrap;
    bit ok;
    do_reset;
    i_inst_ready = 1'b0;
    @(posedge i_clk); #1;
    @(posedge i_clk); #1;
    man_rsp_v = 1'b1; man_inst = 32'h00100093;
    @(posedge i_clk); #1;
    man_rsp_v = 1'b0;
    i_redirect = 1'b1; i_redirect_pc = 64'd64;
    @(posedge i_clk); #1;
    i_redirect = 1'b0;
    n_checks++;
    if (o_imem_addr !== 64'd64 || o_inst !== 32'h00100093 || o_state !== 2'd1) begin
      $display("FAIL rst_setup: addr=%0h inst=%0h state=%0d, required 40/100093/1", o_imem_addr, o_inst, o_state);
      n_errors++;
    end
    #2;
    i_rst_n = 1'b0;
    #1;
    n_checks++;
    if (o_imem_valid !== 1'b0 || o_imem_addr !== 64'd0 || o_inst_valid !== 1'b0 ||
        o_inst !== 32'd0 || o_pc !== 64'd0 || o_halt !== 1'b0 || o_state !== 2'd0) begin
      $display("FAIL rst_async: imem_valid=%b addr=%0h inst_valid=%b inst=%0h pc=%0h halt=%b state=%0d, required all 0",
               o_imem_valid, o_imem_addr, o_inst_valid, o_inst, o_pc, o_halt, o_state);
      n_errors++;
    end
    mem_auto = 1'b1;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    n_checks++;
    if (o_imem_valid !== 1'b1 || o_imem_addr !== 64'd0) begin
      $display("FAIL rst_first_req: valid=%b addr=%0h, required 1/0", o_imem_valid, o_imem_addr); n_errors++;
    end
    i_inst_ready = 1'b1; i_redirect = 1'b1; i_redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    @(posedge i_clk); #1;
    i_redirect = 1'b0;
    wait_inst_valid(ok);
    n_checks++;
    if (!ok || o_pc !== 64'hFFFF_FFFF_FFFF_FFFC || o_inst !== mem[63]) begin
      $display("FAIL wrap_deliver: ok=%b pc=%0h inst=%0h, required 1/fffffffffffffffc/%0h", ok, o_pc, o_inst, mem[63]);
      n_errors++;
    end
    @(posedge i_clk); #1;
    n_checks++;
    if (o_imem_valid !== 1'b1 || o_imem_addr !== 64'd0) begin
      $display("FAIL wrap_next_req: valid=%b addr=%0h, required 1/0", o_imem_valid, o_imem_addr); n_errors++;
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h00000013;
    mem[0]  = 32'h00000013;
    mem[1]  = 32'h00100093;
    mem[2]  = 32'h00200113;
    mem[3]  = 32'hFFFFFFFF;
    mem[16] = 32'h00400213;
    mem[32] = 32'h00800413;
    mem[63] = 32'h00F00793;
    for (int i = 0; i < 4; i++) seq_exp[i] = mem[i];

    test_reset;
    test_sequential;
    test_backpressure;
    test_redirect_wait;
    test_redirect_same_cycle;
    test_halt_gating;
    test_reset_wrap;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
